// File: rtl/act_frame_streamer.sv
// act_frame_streamer
//   Packs NFMAPS channel words from a valid/ready source into one pixel and
//   emits pixels in raster order as single-cycle strobes. The sink has no
//   backpressure, so every emission can be followed by GAP idle cycles.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, abort         frame start request (IDLE only) / abandon the frame
//   s_valid/s_data/s_ready  channel word stream in
//   valid, input_act     one-cycle pixel strobe and packed pixel (channel c at [c*BITWIDTH +: BITWIDTH])
//   col, row             raster position of the pixel being filled/emitted
//   busy, frame_done     frame in progress / one-cycle end-of-frame pulse
module act_frame_streamer #(
    parameter int BITWIDTH = 16,
    parameter int NFMAPS   = 3,
    parameter int NW       = 224,
    parameter int NH       = 224,
    parameter int AW       = 8,
    parameter int GAP      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       s_valid,
    input  logic [BITWIDTH-1:0]        s_data,
    output logic                       s_ready,
    output logic                       valid,
    output logic [NFMAPS*BITWIDTH-1:0] input_act,
    output logic [AW-1:0]              col,
    output logic [AW-1:0]              row,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int CW     = (NFMAPS > 1) ? $clog2(NFMAPS) : 1;
    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
    localparam int GW     = (GAP_M1 > 0) ? $clog2(GAP_M1 + 1) : 1;

    localparam logic [CW-1:0] CH_LAST  = CW'(NFMAPS - 1);
    localparam logic [AW-1:0] COL_LAST = AW'(NW - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(NH - 1);
    localparam logic [GW-1:0] HOLD_END = GW'(GAP_M1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_EMIT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic [CW-1:0]              ch_q;
    logic [GW-1:0]              hold_q;
    logic [NFMAPS*BITWIDTH-1:0] stage_q;
    logic [NFMAPS*BITWIDTH-1:0] act_q;
    logic [AW-1:0]              col_q, row_q;
    logic                       valid_q, s_ready_q, busy_q, done_q;

    logic [AW-1:0]              col_d, row_d;
    logic                       last_pix;
    logic [NFMAPS*BITWIDTH-1:0] pix_d;

    always_comb begin
        last_pix = (col_q == COL_LAST) && (row_q == ROW_LAST);
        col_d    = col_q;
        row_d    = row_q;
        if (!last_pix) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        // The last channel goes straight from s_data into the emitted pixel.
        pix_d = stage_q;
        pix_d[NFMAPS*BITWIDTH-1 -: BITWIDTH] = s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            hold_q    <= '0;
            stage_q   <= '0;
            act_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                state_q   <= S_IDLE;
                ch_q      <= '0;
                s_ready_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state_q   <= S_FILL;
                            ch_q      <= '0;
                            col_q     <= '0;
                            row_q     <= '0;
                            busy_q    <= 1'b1;
                            s_ready_q <= 1'b1;
                        end
                    end
                    S_FILL: begin
                        if (s_valid) begin
                            if (ch_q == CH_LAST) begin
                                act_q     <= pix_d;
                                valid_q   <= 1'b1;
                                s_ready_q <= 1'b0;
                                ch_q      <= '0;
                                state_q   <= S_EMIT;
                            end else begin
                                stage_q[ch_q*BITWIDTH +: BITWIDTH] <= s_data;
                                ch_q <= ch_q + 1'b1;
                            end
                        end
                    end
                    S_EMIT: begin
                        hold_q <= '0;
                        // The final pixel ends the frame immediately; pacing
                        // only matters between pixels of the same frame.
                        if (last_pix) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (GAP > 0) begin
                            state_q <= S_HOLD;
                        end else begin
                            col_q     <= col_d;
                            row_q     <= row_d;
                            s_ready_q <= 1'b1;
                            state_q   <= S_FILL;
                        end
                    end
                    S_HOLD: begin
                        if (hold_q == HOLD_END) begin
                            col_q     <= col_d;
                            row_q     <= row_d;
                            s_ready_q <= 1'b1;
                            state_q   <= S_FILL;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign s_ready    = s_ready_q;
    assign valid      = valid_q;
    assign input_act  = act_q;
    assign col        = col_q;
    assign row        = row_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
